// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit,
// each bit held for CLKS_PER_BIT clocks on a line that idles high.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    tick_last;

    assign tick_last = (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx is computed for the state being entered so the line is a clean flop output.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    shift_d = data_in;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick_last) begin
                    tick_d  = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_d[0];
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (tick_last) begin
                    tick_d  = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx    = tx_q;
    assign done  = done_q;
    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: queued expected frames checked by a line monitor,
// plus directed checks for reset, abort and the W=1/C=1 corner.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       tx, ready, busy, done;

    logic       start1;
    logic [0:0] data1;
    logic       tx1, ready1, busy1, done1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .tx(tx), .ready(ready), .busy(busy), .done(done)
    );

    serial_tx #(.DATA_WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1),
        .tx(tx1), .ready(ready1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: frame cycle n=1..40 is the frame body, n=41 is the done cycle.
    initial begin : monitor
        int n;
        int slot;
        int phase;
        logic in_frame;
        logic bad;
        logic [7:0] word;
        logic [7:0] exp_w;
        in_frame = 1'b0;
        n = 0; bad = 1'b0; word = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && busy) begin
                in_frame = 1'b1;
                n = 0; bad = 1'b0; word = '0;
            end
            if (in_frame) begin
                n++;
                if (n <= 40) begin
                    slot  = (n - 1) / 4;
                    phase = (n - 1) % 4;
                    if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
                    if (slot == 0) begin
                        if (tx !== 1'b0) bad = 1'b1;
                    end else if (slot == 9) begin
                        if (tx !== 1'b1) bad = 1'b1;
                    end else if (phase == 0) begin
                        word[slot-1] = tx;
                    end else if (tx !== word[slot-1]) begin
                        bad = 1'b1;
                    end
                end else begin
                    check("done_cycle{done,ready,busy}", {29'd0, done, ready, busy}, 32'b110);
                    check("frame_shape_bad", {31'd0, bad}, 32'd0);
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("[TB] FAIL unexpected_frame: got %02h, expected none", word);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("frame_data", {24'd0, word}, {24'd0, exp_w});
                        $display("[TB] frame received %02h (expected %02h) at cycle %0d", word, exp_w, cyc);
                    end
                    in_frame = 1'b0;
                end
            end else if (done) begin
                tests++; fails++;
                $display("[TB] FAIL stray_done: got done=1, expected 0 outside frame end");
            end
        end
    end

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("wait_budget_ok", {31'd0, (i < budget)}, 32'd1);
    endtask

    task automatic wait_done(input int budget, output int at);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        at = cyc;
        check("done_seen", {31'd0, (i < budget)}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d1, d2;
        logic [2:0] exp1;
        rst = 1'b0; start = 1'b0; data_in = 8'h00;
        start1 = 1'b0; data1 = 1'b0;

        // reset held with start toggling
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            start = ~start; start1 = ~start1; data_in = 8'h55;
            #1;
            check("reset{tx,ready,busy,done}", {28'd0, tx, ready, busy, done}, 32'b1100);
            check("reset1{tx,ready,busy,done}", {28'd0, tx1, ready1, busy1, done1}, 32'b1100);
        end
        start = 1'b0; start1 = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset_busy", {31'd0, busy}, 32'd0);
        $display("[TB] reset phase complete");

        // single frame A5
        @(posedge clk); #1;
        start = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        start = 1'b0;
        check("accept{tx,ready,busy}", {29'd0, tx, ready, busy}, 32'b001);
        wait_idle(100);

        // start during a frame is ignored
        @(posedge clk); #1;
        start = 1'b1; data_in = 8'h00; exp_q.push_back(8'h00);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(100);
        repeat (50) @(posedge clk);
        #1 check("no_second_frame_busy", {31'd0, busy}, 32'd0);

        // back-to-back with start held, data changed mid-frame
        @(posedge clk); #1;
        start = 1'b1; data_in = 8'h3C;
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 data_in = 8'hC3;
        wait_done(100, d1);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_restart{tx,busy}", {30'd0, tx, busy}, 32'b01);
        wait_done(100, d2);
        check("b2b_done_spacing", d2 - d1, 32'd41);
        wait_idle(100);

        // asynchronous reset during data bit 3 of an F0 frame
        @(posedge clk); #1;
        start = 1'b1; data_in = 8'hF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1 check("pre_abort_tx", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1 check("abort{tx,ready,busy,done}", {28'd0, tx, ready, busy, done}, 32'b1100);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("post_abort_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; data_in = 8'h5A; exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(100);

        // W=1, C=1 corner: tx 0, d, 1 then done
        for (int d = 0; d < 2; d++) begin
            exp1 = {1'b1, d[0], 1'b0};
            @(posedge clk); #1;
            start1 = 1'b1; data1 = d[0];
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                start1 = 1'b0;
                check("w1c1_tx", {31'd0, tx1}, {31'd0, exp1[j]});
                check("w1c1_busy", {31'd0, busy1}, 32'd1);
            end
            @(posedge clk); #1;
            check("w1c1_done{done,ready,tx}", {29'd0, done1, ready1, tx1}, 32'b111);
            @(posedge clk); #1;
            check("w1c1_done_clear", {31'd0, done1}, 32'd0);
            $display("[TB] w1c1 frame data=%0d checked", d);
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
